// File: rtl/cdb_arbiter_rr_pkg.sv
// rtl/cdb_arbiter_rr_pkg.sv - shared types, defaults and helpers for the CDB write-back arbiter
package cdb_arbiter_rr_pkg;

  localparam int CDB_ROB_W  = 4;
  localparam int CDB_DATA_W = 32;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef struct packed {
    logic                  valid;
    logic [CDB_ROB_W-1:0]  rob_entry;
    logic [CDB_DATA_W-1:0] value;
    logic                  taken;
  } cdb_packet_t;

  // (a + b) mod n for operands already in range [0, n)
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/cdb_pick_first.sv
// rtl/cdb_pick_first.sv - find-first-set over a request vector scanned from a start index
module cdb_pick_first
  import cdb_arbiter_rr_pkg::*;
#(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    int p;
    p     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      p = wrap_add(int'(start), j, N);
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = W'(p);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter_rr.sv
// rtl/cdb_arbiter_rr.sv - multi-bus write-back arbiter with round-robin/fixed priority and starvation escalation
module cdb_arbiter_rr
  import cdb_arbiter_rr_pkg::*;
#(
  parameter int   NUM_SRC    = 5,
  parameter int   NUM_CDB    = 1,
  parameter int   ROB_W      = CDB_ROB_W,
  parameter int   DATA_W     = CDB_DATA_W,
  parameter int   MODE       = MODE_RR,
  parameter int   STARVE_MAX = 7,
  localparam int  SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]    src_rob,
  input  logic [NUM_SRC*DATA_W-1:0]   src_value,
  input  logic [NUM_SRC-1:0]          src_taken,
  output logic [NUM_SRC-1:0]          src_yumi,
  output logic [NUM_CDB-1:0]          cdb_valid,
  output logic [NUM_CDB*ROB_W-1:0]    cdb_rob,
  output logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic [NUM_CDB-1:0]          cdb_taken,
  output logic [NUM_CDB*SRC_W-1:0]    cdb_src
);

  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [SRC_W-1:0]                rr_ptr;
  logic [SRC_W-1:0]                base_ptr;
  logic [NUM_SRC-1:0][CNT_W-1:0]   wait_cnt;
  logic [NUM_SRC-1:0]              starved;
  logic [NUM_SRC-1:0]              req_all;
  logic [NUM_CDB-1:0][SRC_W-1:0]   stage_idx;
  logic [NUM_CDB-1:0]              stage_found;
  logic [SRC_W-1:0]                last_idx;
  logic                            any_grant;

  assign base_ptr = (MODE == MODE_FIXED) ? '0 : rr_ptr;
  assign req_all  = (reset || flush) ? '0 : src_valid;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_SRC; i++)
      starved[i] = src_valid[i] && (wait_cnt[i] == STARVE_LIM);
  end

  // Each stage serves starved sources first (from index 0), otherwise scans from base_ptr.
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_stage
    logic [NUM_SRC-1:0] rem_in;
    logic [NUM_SRC-1:0] rem_out;
    logic [NUM_SRC-1:0] starved_rem;
    logic [NUM_SRC-1:0] req;
    logic [SRC_W-1:0]   start;
    logic [NUM_SRC-1:0] grant;

    if (k == 0) begin : g_first
      assign rem_in = req_all;
    end else begin : g_next
      assign rem_in = g_stage[k-1].rem_out;
    end

    assign starved_rem = rem_in & starved;
    assign req         = (|starved_rem) ? starved_rem : rem_in;
    assign start       = (|starved_rem) ? '0 : base_ptr;

    cdb_pick_first #(
      .N (NUM_SRC),
      .W (SRC_W)
    ) u_pick (
      .req   (req),
      .start (start),
      .grant (grant),
      .idx   (stage_idx[k]),
      .found (stage_found[k])
    );

    assign rem_out = rem_in & ~grant;
  end

  assign src_yumi = req_all & ~g_stage[NUM_CDB-1].rem_out;

  always_comb begin
    last_idx  = '0;
    any_grant = |stage_found;
    for (int k = 0; k < NUM_CDB; k++)
      if (stage_found[k]) last_idx = stage_idx[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (!flush && any_grant) begin
      rr_ptr <= SRC_W'(wrap_add(int'(last_idx), 1, NUM_SRC));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush || !src_valid[i] || src_yumi[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != STARVE_LIM)
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid <= '0;
      cdb_rob   <= '0;
      cdb_value <= '0;
      cdb_taken <= '0;
      cdb_src   <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid[k]                  <= stage_found[k];
        cdb_src[k*SRC_W +: SRC_W]     <= stage_found[k] ? stage_idx[k] : '0;
        cdb_rob[k*ROB_W +: ROB_W]     <= stage_found[k] ? src_rob[stage_idx[k]*ROB_W +: ROB_W] : '0;
        cdb_value[k*DATA_W +: DATA_W] <= stage_found[k] ? src_value[stage_idx[k]*DATA_W +: DATA_W] : '0;
        cdb_taken[k]                  <= stage_found[k] ? src_taken[stage_idx[k]] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// tb/tb_cdb_arbiter_rr.sv - scoreboard bench for the CDB arbiter in three configurations
module tb_cdb_arbiter_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]   v0, v1, v2;
  logic         f0, f1, f2;
  logic [19:0]  src_rob;
  logic [159:0] src_value;
  logic [4:0]   src_taken;

  logic [4:0]  y0, y1, y2;
  logic [0:0]  cv0, ct0, cv2, ct2;
  logic [3:0]  cr0, cr2;
  logic [31:0] cval0, cval2;
  logic [2:0]  cs0, cs2;
  logic [1:0]  cv1, ct1;
  logic [7:0]  cr1;
  logic [63:0] cval1;
  logic [5:0]  cs1;

  logic [3:0]  rob_t [5];
  logic [31:0] val_t [5];
  logic        tk_t  [5];

  cdb_arbiter_rr #(.NUM_SRC(5), .NUM_CDB(1), .ROB_W(4), .DATA_W(32), .MODE(0), .STARVE_MAX(7)) u0 (
    .clk(clk), .reset(reset), .flush(f0), .src_valid(v0), .src_rob(src_rob), .src_value(src_value),
    .src_taken(src_taken), .src_yumi(y0), .cdb_valid(cv0), .cdb_rob(cr0), .cdb_value(cval0),
    .cdb_taken(ct0), .cdb_src(cs0));

  cdb_arbiter_rr #(.NUM_SRC(5), .NUM_CDB(2), .ROB_W(4), .DATA_W(32), .MODE(0), .STARVE_MAX(7)) u1 (
    .clk(clk), .reset(reset), .flush(f1), .src_valid(v1), .src_rob(src_rob), .src_value(src_value),
    .src_taken(src_taken), .src_yumi(y1), .cdb_valid(cv1), .cdb_rob(cr1), .cdb_value(cval1),
    .cdb_taken(ct1), .cdb_src(cs1));

  cdb_arbiter_rr #(.NUM_SRC(5), .NUM_CDB(1), .ROB_W(4), .DATA_W(32), .MODE(1), .STARVE_MAX(3)) u2 (
    .clk(clk), .reset(reset), .flush(f2), .src_valid(v2), .src_rob(src_rob), .src_value(src_value),
    .src_taken(src_taken), .src_yumi(y2), .cdb_valid(cv2), .cdb_rob(cr2), .cdb_value(cval2),
    .cdb_taken(ct2), .cdb_src(cs2));

  typedef struct {
    int cyc;
    int inst;
    int bus;
    int src;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input int bus, input int src);
    exp_t e;
    e = '{cyc + 1, inst, bus, src};
    q.push_back(e);
  endtask

  task automatic mon(input int inst, input int bus, input logic [2:0] src, input logic [3:0] rob,
                     input logic [31:0] val, input logic tk);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL cdb_unexpected inst=%0d bus=%0d cyc=%0d: got src %0d, expected no broadcast",
               inst, bus, cyc, src);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.inst != inst || e.bus != bus || src !== 3'(e.src) ||
          rob !== rob_t[e.src] || val !== val_t[e.src] || tk !== tk_t[e.src]) begin
        miscompares++;
        $display("FAIL cdb_pkt: got cyc=%0d inst=%0d bus=%0d src=%0d rob=%h val=%h tk=%b expected cyc=%0d inst=%0d bus=%0d src=%0d rob=%h val=%h tk=%b",
                 cyc, inst, bus, src, rob, val, tk,
                 e.cyc, e.inst, e.bus, e.src, rob_t[e.src], val_t[e.src], tk_t[e.src]);
      end
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (cv0[0]) mon(0, 0, cs0, cr0, cval0, ct0[0]);
    for (int b = 0; b < 2; b++)
      if (cv1[b]) mon(1, b, cs1[b*3 +: 3], cr1[b*4 +: 4], cval1[b*32 +: 32], ct1[b]);
    if (cv2[0]) mon(2, 0, cs2, cr2, cval2, ct2[0]);
  end

  task automatic step(input int inst, input logic [4:0] v, input logic fl, input logic [4:0] ey,
                      input string name);
    logic [4:0] act;
    case (inst)
      0: begin v0 = v; f0 = fl; end
      1: begin v1 = v; f1 = fl; end
      default: begin v2 = v; f2 = fl; end
    endcase
    #1;
    case (inst)
      0: act = y0;
      1: act = y1;
      default: act = y2;
    endcase
    chk(name, 32'(act), 32'(ey));
  endtask

  initial begin
    rob_t = '{4'h3, 4'h7, 4'hA, 4'h5, 4'hC};
    val_t = '{32'h1111_0001, 32'h2222_0002, 32'hDEAD_BEEF, 32'h4444_0004, 32'h5555_0005};
    tk_t  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      src_rob[i*4 +: 4]    = rob_t[i];
      src_value[i*32 +: 32] = val_t[i];
      src_taken[i]         = tk_t[i];
    end
    reset = 1'b1;
    v0 = 5'h1f; v1 = 5'h1f; v2 = 5'h1f;
    f0 = 1'b0;  f1 = 1'b0;  f2 = 1'b0;

    #1;
    chk("reset_yumi0", 32'(y0), 0);
    chk("reset_yumi1", 32'(y1), 0);
    chk("reset_yumi2", 32'(y2), 0);
    chk("reset_cdb_valid0", 32'(cv0), 0);
    repeat (2) @(negedge clk);
    chk("reset_held_cdb_valid1", 32'(cv1), 0);
    chk("reset_held_yumi0", 32'(y0), 0);

    @(negedge clk);
    reset = 1'b0; v1 = 5'h00; v2 = 5'h00;
    step(0, 5'h1f, 1'b0, 5'b00001, "rr_first_after_reset");
    push(0, 0, 0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      step(0, 5'h1f, 1'b0, 5'(1 << (i % 5)), "rr_sequence");
      push(0, 0, i % 5);
    end

    @(negedge clk); step(0, 5'h1f, 1'b0, 5'b00010, "pre_flush_c0"); push(0, 0, 1);
    @(negedge clk); step(0, 5'h1f, 1'b0, 5'b00100, "pre_flush_c1"); push(0, 0, 2);
    @(negedge clk); step(0, 5'h1f, 1'b1, 5'b00000, "flush_yumi");
    @(negedge clk); step(0, 5'h1f, 1'b0, 5'b01000, "flush_resume_rr_ptr");
    chk("flush_cdb_valid", 32'(cv0), 0);
    push(0, 0, 3);

    @(negedge clk); step(0, 5'b00100, 1'b0, 5'b00100, "payload_yumi"); push(0, 0, 2);
    @(negedge clk); step(0, 5'b00000, 1'b0, 5'b00000, "idle0");

    @(negedge clk); step(1, 5'b11010, 1'b0, 5'b01010, "cdb2_cycle0");
    push(1, 0, 1); push(1, 1, 3);
    @(negedge clk); step(1, 5'b10000, 1'b0, 5'b10000, "cdb2_cycle1");
    push(1, 0, 4);
    @(negedge clk); step(1, 5'b00000, 1'b0, 5'b00000, "idle1");

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      step(2, 5'b10001, 1'b0, (i % 4 == 3) ? 5'b10000 : 5'b00001, "fixed_starve");
      if (i % 4 == 3) chk("wait4_at_forced_grant", 32'(u2.wait_cnt[4]), 3);
      push(2, 0, (i % 4 == 3) ? 4 : 0);
    end
    @(negedge clk); step(2, 5'b00000, 1'b0, 5'b00000, "idle2");

    @(negedge clk); step(0, 5'b00001, 1'b0, 5'b00001, "pre_reset_yumi");
    @(posedge clk);
    #1;
    chk("pre_reset_cdb_valid", 32'(cv0), 1);
    chk("pre_reset_cdb_src", 32'(cs0), 0);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_cdb_valid", 32'(cv0), 0);
    chk("async_reset_yumi", 32'(y0), 0);
    @(negedge clk);
    reset = 1'b0; v0 = 5'h00;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
